// File: rtl/rr_burst_scheduler.sv
// rr_burst_scheduler
// Round-robin owner of a single shared burst resource. A grant stays with its
// owner until the owner signals done, drops its request, or reaches MAX_HOLD
// cycles. Every release is followed by one dead cycle, so two grants can never
// overlap. All outputs come straight from registers.
module rr_burst_scheduler #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           tmo,
    output logic [IDW-1:0] tmo_id
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_GAP
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_gnt;
    logic           r_gnt_valid;
    logic [IDW-1:0] r_gnt_id;
    logic           r_tmo;
    logic [IDW-1:0] r_tmo_id;
    logic [CW-1:0]  r_hold_cnt;
    logic [IDW-1:0] r_last_owner;

    logic           w_pick_valid;
    logic [IDW-1:0] w_pick_id;
    logic [IDW-1:0] w_cand;
    logic           w_done_own;
    logic           w_req_own;
    logic           w_at_limit;
    logic           w_release;

    // Round-robin pick: first requester after last_owner, scanning mod N.
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_id    = '0;
        w_cand       = '0;
        // Scan from farthest to nearest so the nearest set bit is written last.
        for (int k = N; k >= 1; k--) begin
            w_cand = IDW'((int'(r_last_owner) + k) % N);
            if (req[w_cand]) begin
                w_pick_valid = 1'b1;
                w_pick_id    = w_cand;
            end
        end
    end

    // Release conditions for the current owner; done/req of others are ignored.
    always_comb begin
        w_done_own = done[r_gnt_id];
        w_req_own  = req[r_gnt_id];
        w_at_limit = (r_hold_cnt == CW'(MAX_HOLD));
        w_release  = w_done_own | ~w_req_own | w_at_limit;
    end

    // Scheduler FSM with registered grant, id and timeout outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_gnt        <= '0;
            r_gnt_valid  <= 1'b0;
            r_gnt_id     <= '0;
            r_tmo        <= 1'b0;
            r_tmo_id     <= '0;
            r_hold_cnt   <= '0;
            // Pointer parked on the last requester so requester 0 wins first.
            r_last_owner <= IDW'(N - 1);
        end else begin
            r_tmo <= 1'b0;
            case (r_state)
                S_IDLE, S_GAP: begin
                    if (w_pick_valid) begin
                        r_state     <= S_BUSY;
                        r_gnt       <= N'(1) << w_pick_id;
                        r_gnt_valid <= 1'b1;
                        r_gnt_id    <= w_pick_id;
                        r_hold_cnt  <= CW'(1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (w_release) begin
                        r_state      <= S_GAP;
                        r_gnt        <= '0;
                        r_gnt_valid  <= 1'b0;
                        r_gnt_id     <= '0;
                        r_hold_cnt   <= '0;
                        r_last_owner <= r_gnt_id;
                        // A voluntary release in the same cycle suppresses the timeout.
                        if (w_req_own && !w_done_own) begin
                            r_tmo    <= 1'b1;
                            r_tmo_id <= r_gnt_id;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign tmo       = r_tmo;
    assign tmo_id    = r_tmo_id;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Testbench for rr_burst_scheduler: directed scenarios followed by random
// traffic, all checked against a cycle-level ownership model.
module tb_rr_burst_scheduler;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;
    localparam int IDW      = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           tmo;
    logic [IDW-1:0] tmo_id;

    rr_burst_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .tmo       (tmo),
        .tmo_id    (tmo_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the resource, for how long, who owned it last.
    int   m_owner;    // -1 when nobody owns it
    int   m_hold;     // cycles the current owner has held the grant
    int   m_last;     // previous owner, start point of the round-robin scan
    logic m_tmo;
    int   m_tmo_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_hold   = 0;
        m_last   = N - 1;
        m_tmo    = 1'b0;
        m_tmo_id = 0;
    endtask

    // One clock edge of the scheduling rules, using the inputs present at the edge.
    task automatic model_edge();
        m_tmo = 1'b0;
        if (m_owner >= 0) begin
            if (done[m_owner] || !req[m_owner] || m_hold == MAX_HOLD) begin
                if (!done[m_owner] && req[m_owner]) begin
                    m_tmo    = 1'b1;
                    m_tmo_id = m_owner;
                end
                m_last  = m_owner;
                m_owner = -1;   // the following cycle is the dead cycle
            end else begin
                m_hold++;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (req[c] && m_owner < 0) begin
                    m_owner = c;
                    m_hold  = 1;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        check({tag, ".gnt"},       32'(gnt),       exp_gnt);
        check({tag, ".gnt_valid"}, 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        check({tag, ".gnt_id"},    32'(gnt_id),    (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check({tag, ".tmo"},       32'(tmo),       32'(m_tmo));
        if (m_tmo) check({tag, ".tmo_id"}, 32'(tmo_id), 32'(m_tmo_id));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    // Assert reset between edges and confirm the outputs clear without a clock.
    task automatic mid_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, ".gnt"},       32'(gnt),       32'd0);
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'd0);
        check({tag, ".gnt_id"},    32'(gnt_id),    32'd0);
        check({tag, ".tmo"},       32'(tmo),       32'd0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int owners[$];
        int exp_owners[5];
        logic prev_valid;
        int cnt_gnt;
        int cnt_tmo;
        int guard;

        exp_owners = '{0, 1, 2, 3, 0};

        // Reset state
        rst  = 1'b1;
        req  = '0;
        done = '0;
        model_reset();
        #12;
        check_outputs("reset");
        check("reset.tmo_id", 32'(tmo_id), 32'd0);
        rst = 1'b0;

        // 1) single request, one-cycle latency
        req = 4'b0001;
        step("t1");
        check("t1.gnt_explicit", 32'(gnt), 32'h1);

        // 2) all requesting, done two cycles into each grant
        mid_reset("t2_rst");
        req        = 4'b1111;
        prev_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            done = (m_owner >= 0 && m_hold == 2) ? 4'(1 << m_owner) : 4'b0000;
            step("t2");
            if (gnt_valid && !prev_valid) owners.push_back(int'(gnt_id));
            prev_valid = gnt_valid;
        end
        done = '0;
        check("t2.grant_count", 32'(owners.size()), 32'd5);
        for (int i = 0; i < owners.size() && i < 5; i++)
            check("t2.owner_order", 32'(owners[i]), 32'(exp_owners[i]));

        // 3) lone requester runs into the MAX_HOLD limit
        req = '0;
        step("t3_idle");
        step("t3_idle");
        req     = 4'b0100;
        cnt_gnt = 0;
        cnt_tmo = 0;
        for (int i = 0; i < 20; i++) begin
            step("t3");
            if (i < 17 && gnt == 4'b0100) cnt_gnt++;
            if (tmo) cnt_tmo++;
        end
        check("t3.hold_cycles", 32'(cnt_gnt), 32'(MAX_HOLD));
        check("t3.tmo_pulses",  32'(cnt_tmo), 32'd1);

        // 4) non-owner done ignored; owner done on the limit cycle beats timeout
        req = '0;
        step("t4_idle");
        step("t4_idle");
        req = 4'b0010;
        step("t4_grant");
        done  = 4'b0001;
        guard = 0;
        while (m_hold < MAX_HOLD && guard < 40) begin
            step("t4_hold");
            guard++;
        end
        check("t4.reached_limit", 32'(m_hold), 32'(MAX_HOLD));
        done = 4'b0010;
        step("t4_release");
        check("t4.tmo_suppressed", 32'(tmo), 32'd0);
        check("t4.gnt_dropped",    32'(gnt), 32'd0);
        done = '0;
        req  = '0;
        step("t4_gap");

        // 5) reset while requester 3 owns the resource
        req = 4'b1000;
        step("t5_grant");
        step("t5_hold");
        check("t5.owner3", 32'(gnt), 32'h8);
        mid_reset("t5_rst");
        req = 4'b1010;
        step("t5_after");
        check("t5.winner1", 32'(gnt), 32'h2);

        // 6) owner drops its request without done
        req = '0;
        step("t6_idle");
        step("t6_idle");
        req = 4'b0001;
        step("t6_grant");
        step("t6_hold");
        req = '0;
        step("t6_release");
        check("t6.tmo_clear", 32'(tmo), 32'd0);
        step("t6_gap");
        step("t6_idle_again");

        // Random traffic: slowly changing requests, sparse done strobes
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) req = 4'($urandom);
            done = '0;
            for (int b = 0; b < N; b++)
                if ($urandom_range(15) == 0) done[b] = 1'b1;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
